// File: rtl/fp_mul_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_normalize_round
// Description : Normalise, round-to-nearest-even and pack stage of the
//               single-precision multiplier; two-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_normalize_round #(
    parameter int EXP_W = 10,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [47:0]      in_mant,
    input  logic [5:0]       in_lzc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact,
    output logic             out_zero
);

    localparam int E1_W = EXP_W + 1;
    localparam int E2_W = EXP_W + 2;

    logic              r_s1_valid;
    logic              r_s1_sign;
    logic              r_s1_zero;
    logic [46:0]       r_s1_norm;
    logic [E1_W-1:0]   r_s1_e1;

    logic              r_out_valid;
    logic [31:0]       r_out_result;
    logic              r_out_overflow;
    logic              r_out_underflow;
    logic              r_out_inexact;
    logic              r_out_zero;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [47:0]       w_norm;
    logic [E1_W-1:0]   w_e1;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_norm = in_mant << in_lzc;
    assign w_e1   = {in_exp[EXP_W-1], in_exp} + E1_W'(1) - {{(E1_W-6){1'b0}}, in_lzc};

    // Bit 47 of the normalised mantissa is the hidden one and is not stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_norm  <= '0;
            r_s1_e1    <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign <= in_sign;
                r_s1_zero <= (in_mant == '0);
                r_s1_norm <= w_norm[46:0];
                r_s1_e1   <= w_e1;
            end
        end
    end

    logic [22:0]     w_frac;
    logic            w_lsb;
    logic            w_guard;
    logic            w_sticky;
    logic            w_up;
    logic            w_carry;
    logic [22:0]     w_frac_rnd;
    logic [E2_W-1:0] w_e2;
    logic            w_ovf;
    logic            w_udf;
    logic            w_inexact_r;

    assign w_frac      = r_s1_norm[46:24];
    assign w_lsb       = r_s1_norm[24];
    assign w_guard     = r_s1_norm[23];
    assign w_sticky    = |r_s1_norm[22:0];
    assign w_up        = w_guard && (w_sticky || w_lsb);
    // Incrementing {1,frac} carries out only when every fraction bit is set.
    assign w_carry     = w_up && (&w_frac);
    assign w_frac_rnd  = w_frac + 23'(w_up);
    assign w_e2        = {r_s1_e1[E1_W-1], r_s1_e1} + E2_W'(w_carry);
    assign w_ovf       = !w_e2[E2_W-1] && (w_e2[E2_W-2:0] >= (E2_W-1)'(255));
    assign w_udf       = w_e2[E2_W-1] || (w_e2 == '0);
    assign w_inexact_r = w_guard || w_sticky;

    logic [31:0] w_result;
    logic        w_f_ovf;
    logic        w_f_udf;
    logic        w_f_inx;
    logic        w_f_zero;

    always_comb begin
        w_result = {r_s1_sign, 31'b0};
        w_f_ovf  = 1'b0;
        w_f_udf  = 1'b0;
        w_f_inx  = 1'b0;
        w_f_zero = 1'b0;
        if (r_s1_zero) begin
            w_f_zero = 1'b1;
        end else if (w_ovf) begin
            w_result = {r_s1_sign, 8'hFF, 23'b0};
            w_f_ovf  = 1'b1;
            w_f_inx  = 1'b1;
        end else if (w_udf) begin
            w_f_udf  = 1'b1;
            w_f_inx  = 1'b1;
        end else begin
            w_result = {r_s1_sign, w_e2[7:0], w_frac_rnd};
            w_f_inx  = w_inexact_r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_result    <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= 1'b0;
            r_out_zero      <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result    <= w_result;
                r_out_overflow  <= w_f_ovf;
                r_out_underflow <= w_f_udf;
                r_out_inexact   <= w_f_inx;
                r_out_zero      <= w_f_zero;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_overflow  = r_out_overflow;
    assign out_underflow = r_out_underflow;
    assign out_inexact   = r_out_inexact;
    assign out_zero      = r_out_zero;

    // A normal result never carries the reserved all-ones or all-zeros exponent.
    a_normal_exp: assert property (@(posedge clk) disable iff (rst)
        r_out_valid && !r_out_zero && !r_out_overflow && !r_out_underflow
        |-> (r_out_result[30:23] != 8'(2*BIAS+1)) && (r_out_result[30:23] != 8'd0));

    a_lzc_consistent: assert property (@(posedge clk) disable iff (rst)
        in_valid && w_s1_adv && (in_mant != '0) |-> w_norm[47]);

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_normalize_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_normalize_round
// Description : Directed table, backpressure/reset sequences and randomized
//               traffic checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_normalize_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [47:0] in_mant = '0;
    logic [5:0]  in_lzc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;
    logic        out_zero;

    always #5 clk = ~clk;

    fp_mul_normalize_round #(.EXP_W(10), .BIAS(127)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_exp(in_exp), .in_mant(in_mant), .in_lzc(in_lzc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .out_inexact(out_inexact), .out_zero(out_zero)
    );

    typedef struct {
        logic        sign;
        logic [9:0]  exp;
        logic [47:0] mant;
        logic [5:0]  lzc;
        logic [31:0] res;
        logic [3:0]  flags;  // {ovf, udf, inx, zero}
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
    } res_t;

    int   vectors = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference: take the top 24 bits of the normalised product and compare the
    // discarded remainder with one half ulp.
    function automatic res_t model(input logic s, input logic [9:0] e,
                                   input logic [47:0] m, input logic [5:0] lz);
        res_t r;
        longint unsigned norm, top, rem;
        int ee;
        if (m == 48'h0) begin
            r.res = {s, 31'b0}; r.flags = 4'b0001; return r;
        end
        norm = (longint'(m) << lz) & 64'hFFFF_FFFF_FFFF;
        top  = norm >> 24;
        rem  = norm & 64'hFF_FFFF;
        ee   = int'($signed(e)) + 1 - int'(lz);
        if (rem > 64'h80_0000 || (rem == 64'h80_0000 && top[0])) top++;
        if (top == 64'h100_0000) begin top = 64'h80_0000; ee++; end
        if (ee >= 255) begin
            r.res = {s, 8'hFF, 23'b0}; r.flags = 4'b1010;
        end else if (ee <= 0) begin
            r.res = {s, 31'b0}; r.flags = 4'b0110;
        end else begin
            r.res = {s, ee[7:0], top[22:0]}; r.flags = {2'b00, rem != 0, 1'b0};
        end
        return r;
    endfunction

    task automatic drive(input logic s, input logic [9:0] e,
                         input logic [47:0] m, input logic [5:0] lz);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_lzc = lz;
    endtask

    // Called just after a falling edge; returns whether the current input beat
    // is taken on the coming rising edge and checks any departing result.
    task automatic step(output bit acc);
        res_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL spurious_out: got result %h, expected no output", out_result);
            end else begin
                e = exp_q.pop_front();
                chk("result", out_result, e.res);
                chk("flags", {28'b0, out_overflow, out_underflow, out_inexact, out_zero},
                    {28'b0, e.flags});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step(acc);
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rand_beat();
        logic [47:0] m;
        logic [5:0]  lz;
        logic [9:0]  e;
        lz = 6'($urandom_range(0, 47));
        m  = 48'({$urandom(), $urandom()});
        m  = (m >> lz) | (48'h1 << (47 - lz));
        if ($urandom_range(0, 15) == 0) m = '0;
        e  = 10'($urandom_range(0, 420) - 110);
        drive(1'($urandom()), e, m, lz);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit   acc;
        res_t r;

        tbl[0]  = '{1'b0, 10'd127, 48'h4000_0000_0000, 6'd1, 32'h3F80_0000, 4'b0000};
        tbl[1]  = '{1'b0, 10'd127, 48'h8000_0000_0000, 6'd0, 32'h4000_0000, 4'b0000};
        tbl[2]  = '{1'b0, 10'd127, 48'h4000_0040_0000, 6'd1, 32'h3F80_0000, 4'b0010};
        tbl[3]  = '{1'b0, 10'd127, 48'h4000_00C0_0000, 6'd1, 32'h3F80_0002, 4'b0010};
        tbl[4]  = '{1'b0, 10'd127, 48'hFFFF_FFFF_FFFF, 6'd0, 32'h4080_0000, 4'b0010};
        tbl[5]  = '{1'b0, 10'd254, 48'h8000_0000_0000, 6'd0, 32'h7F80_0000, 4'b1010};
        tbl[6]  = '{1'b0, 10'd1,   48'h2000_0000_0000, 6'd2, 32'h0000_0000, 4'b0110};
        tbl[7]  = '{1'b1, 10'd127, 48'h0,              6'd0, 32'h8000_0000, 4'b0001};
        tbl[8]  = '{1'b0, 10'd253, 48'hFFFF_FFFF_FFFF, 6'd0, 32'h7F80_0000, 4'b1010};
        tbl[9]  = '{1'b0, 10'h3FF, 48'hFFFF_FFFF_FFFF, 6'd0, 32'h0080_0000, 4'b0010};
        tbl[10] = '{1'b1, 10'h300, 48'h8000_0000_0000, 6'd0, 32'h8000_0000, 4'b0110};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_result", out_result, 32'd0);
        chk("reset_flags", {28'b0, out_overflow, out_underflow, out_inexact, out_zero}, 32'd0);
        @(negedge clk);

        // Directed vectors
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].sign, tbl[i].exp, tbl[i].mant, tbl[i].lzc);
            acc = 1'b0;
            for (int k = 0; k < 10 && !acc; k++) step(acc);
            if (acc) exp_q.push_back('{tbl[i].res, tbl[i].flags});
        end
        drain();

        // Backpressure: three beats against a stalled output
        out_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 6'd1);
        #1 chk("bp_ready0", {31'b0, in_ready}, 32'd1);
        step(acc);
        if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
        drive(1'b1, 10'd130, 48'h6000_0000_0001, 6'd1);
        #1 chk("bp_ready1", {31'b0, in_ready}, 32'd1);
        step(acc);
        if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
        drive(1'b0, 10'd120, 48'h1234_5678_9ABC, 6'd3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready_low", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            r = (exp_q.size() > 0) ? exp_q[0] : '{32'hxxxx_xxxx, 4'hx};
            chk("bp_head_stable", out_result, r.res);
            step(acc);
            if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
        end
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            step(acc);
            if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
        end
        chk("bp_third_accepted", {31'b0, acc}, 32'd1);
        drain();

        // Reset with two beats in flight: neither may ever appear
        out_ready = 1'b0;
        drive(1'b0, 10'd127, 48'h8000_0000_0000, 6'd0);
        step(acc);
        drive(1'b1, 10'd100, 48'h4000_0000_0000, 6'd1);
        step(acc);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1 chk("rst_no_emit", {31'b0, out_valid}, 32'd0);
            step(acc);
        end

        // Randomized traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) rand_beat();
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) exp_q.push_back(model(in_sign, in_exp, in_mant, in_lzc));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
